// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection, bubble insertion and stall
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid                   ID holds a real instruction
//   id_pc_plus4 .. id_imm      DW-wide operands from ID
//   id_rs, id_rt, id_rd        register specifiers
//   id_funct, id_alu_op        ALU control inputs
//   id_reg_write .. id_reg_dst main-control signals
//   flush_i                    kill the ID instruction (branch taken downstream)
//   hold_i                     freeze this register (downstream busy)
//   ex_*                       registered copies presented to EX
//   stall_o                    combinational; hold PC and IF/ID this cycle
//   perf_bubbles               saturating count of load-use bubbles
module id_ex_stage #(
    parameter int DW  = 32,
    parameter int PCW = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic [DW-1:0]  id_pc_plus4,
    input  logic [DW-1:0]  id_rs_data,
    input  logic [DW-1:0]  id_rt_data,
    input  logic [DW-1:0]  id_imm,
    input  logic [4:0]     id_rs,
    input  logic [4:0]     id_rt,
    input  logic [4:0]     id_rd,
    input  logic [5:0]     id_funct,
    input  logic [1:0]     id_alu_op,
    input  logic           id_reg_write,
    input  logic           id_mem_to_reg,
    input  logic           id_mem_read,
    input  logic           id_mem_write,
    input  logic           id_branch,
    input  logic           id_alu_src,
    input  logic           id_reg_dst,
    input  logic           flush_i,
    input  logic           hold_i,
    output logic           ex_valid,
    output logic [DW-1:0]  ex_pc_plus4,
    output logic [DW-1:0]  ex_rs_data,
    output logic [DW-1:0]  ex_rt_data,
    output logic [DW-1:0]  ex_imm,
    output logic [4:0]     ex_rs,
    output logic [4:0]     ex_rt,
    output logic [4:0]     ex_rd,
    output logic [5:0]     ex_funct,
    output logic [1:0]     ex_alu_op,
    output logic           ex_reg_write,
    output logic           ex_mem_to_reg,
    output logic           ex_mem_read,
    output logic           ex_mem_write,
    output logic           ex_branch,
    output logic           ex_alu_src,
    output logic           ex_reg_dst,
    output logic           stall_o,
    output logic [PCW-1:0] perf_bubbles
);

    logic haz;
    logic bubble;
    logic count_en;

    // id_rt is compared for every opcode; a spurious stall is cheaper than decoding the format
    assign haz = ex_valid & ex_mem_read & id_valid & (ex_rt != 5'd0) &
                 ((ex_rt == id_rs) | (ex_rt == id_rt));

    assign stall_o  = (haz | hold_i) & ~flush_i;
    // flush beats hold; hold beats hazard
    assign bubble   = flush_i | (~hold_i & haz);
    assign count_en = ~flush_i & ~hold_i & haz & (perf_bubbles != {PCW{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_pc_plus4   <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_funct      <= '0;
            ex_alu_op     <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_branch     <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_dst    <= 1'b0;
        end else if (bubble) begin
            ex_valid      <= 1'b0;
            ex_pc_plus4   <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_funct      <= '0;
            ex_alu_op     <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_branch     <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_dst    <= 1'b0;
        end else if (!hold_i) begin
            // an invalid ID slot loads as-is; downstream qualifies with ex_valid
            ex_valid      <= id_valid;
            ex_pc_plus4   <= id_pc_plus4;
            ex_rs_data    <= id_rs_data;
            ex_rt_data    <= id_rt_data;
            ex_imm        <= id_imm;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
            ex_funct      <= id_funct;
            ex_alu_op     <= id_alu_op;
            ex_reg_write  <= id_reg_write;
            ex_mem_to_reg <= id_mem_to_reg;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_branch     <= id_branch;
            ex_alu_src    <= id_alu_src;
            ex_reg_dst    <= id_reg_dst;
        end
    end

    // only hazard bubbles are counted; saturates instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_bubbles <= '0;
        else if (count_en)
            perf_bubbles <= perf_bubbles + 1'b1;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scoreboard bench for id_ex_stage
module tb_id_ex_stage;

    typedef struct packed {
        logic        v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  fn;
        logic [1:0]  op;
        logic [6:0]  c;
        logic [31:0] d;
    } fld_t;

    typedef struct packed {
        fld_t       f;
        logic       s;
        logic [3:0] p;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc_plus4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [5:0]  id_funct;
    logic [1:0]  id_alu_op;
    logic        id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst;
    logic        flush_i, hold_i;
    logic        ex_valid;
    logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [5:0]  ex_funct;
    logic [1:0]  ex_alu_op;
    logic        ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst;
    logic        stall_o;
    logic [3:0]  perf_bubbles;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    id_ex_stage #(.DW(32), .PCW(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_pc_plus4(id_pc_plus4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct), .id_alu_op(id_alu_op),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .flush_i(flush_i), .hold_i(hold_i), .ex_valid(ex_valid),
        .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct), .ex_alu_op(ex_alu_op),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst),
        .stall_o(stall_o), .perf_bubbles(perf_bubbles)
    );

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
        end
    endtask

    // monitor: one expectation per cycle, compared mid-cycle on the falling edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t r;
            r = q.pop_front();
            chk("ex_valid", {127'd0, ex_valid}, {127'd0, r.f.v});
            chk("spec", {105'd0, ex_rs, ex_rt, ex_rd, ex_funct, ex_alu_op},
                        {105'd0, r.f.rs, r.f.rt, r.f.rd, r.f.fn, r.f.op});
            chk("ctrl", {121'd0, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst},
                        {121'd0, r.f.c});
            chk("data", {ex_pc_plus4, ex_rs_data, ex_rt_data, ex_imm},
                        {r.f.d, r.f.d * 32'd3, r.f.d * 32'd5, r.f.d * 32'd7});
            chk("stall_o", {127'd0, stall_o}, {127'd0, r.s});
            chk("perf_bubbles", {124'd0, perf_bubbles}, {124'd0, r.p});
        end
    end

    function automatic fld_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                input logic [5:0] fn, input logic [1:0] op, input logic [6:0] c, input logic [31:0] d);
        return {v, rs, rt, rd, fn, op, c, d};
    endfunction

    function automatic logic [3:0] sat(input int n);
        return (n > 15) ? 4'hF : n[3:0];
    endfunction

    task automatic drive(input fld_t i, input logic f, input logic h);
        id_valid    = i.v;
        id_rs       = i.rs;
        id_rt       = i.rt;
        id_rd       = i.rd;
        id_funct    = i.fn;
        id_alu_op   = i.op;
        {id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src, id_reg_dst} = i.c;
        id_pc_plus4 = i.d;
        id_rs_data  = i.d * 32'd3;
        id_rt_data  = i.d * 32'd5;
        id_imm      = i.d * 32'd7;
        flush_i     = f;
        hold_i      = h;
    endtask

    // drive a cycle's inputs and queue the outputs expected during that same cycle
    task automatic step(input fld_t i, input logic f, input logic h, input fld_t e, input logic s, input logic [3:0] p);
        drive(i, f, h);
        q.push_back({e, s, p});
        @(posedge clk);
        #1;
    endtask

    // controls: {reg_write, mem_to_reg, mem_read, mem_write, branch, alu_src, reg_dst}
    fld_t z, ones, add1, lw8, addd, lw0, a0;

    initial begin
        z    = '0;
        ones = '1;
        add1 = mk(1'b1, 5'd9,  5'd10, 5'd8,  6'h20, 2'b10, 7'b1000001, 32'h0000_00A0);
        lw8  = mk(1'b1, 5'd29, 5'd8,  5'd0,  6'h00, 2'b00, 7'b1110010, 32'h0000_00B0);
        addd = mk(1'b1, 5'd8,  5'd9,  5'd10, 6'h20, 2'b10, 7'b1000001, 32'h0000_00C0);
        lw0  = mk(1'b1, 5'd29, 5'd0,  5'd0,  6'h00, 2'b00, 7'b1110010, 32'h0000_00D0);
        a0   = mk(1'b1, 5'd0,  5'd0,  5'd11, 6'h20, 2'b10, 7'b1000001, 32'h0000_00E0);
        rst_n = 1'b0;
        drive(ones, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        q.push_back({z, 1'b0, 4'd0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // pass-through
        step(add1, 0, 0, z,    0, 0);
        step(z,    0, 0, add1, 0, 0);
        // load-use
        step(lw8,  0, 0, z,    0, 0);
        step(addd, 0, 0, lw8,  1, 0);
        step(addd, 0, 0, z,    0, 1);
        step(z,    0, 0, addd, 0, 1);
        // $0 never hazards
        step(lw0,  0, 0, z,    0, 1);
        step(a0,   0, 0, lw0,  0, 1);
        step(z,    0, 0, a0,   0, 1);
        // flush beats hazard
        step(lw8,  0, 0, z,    0, 1);
        step(addd, 1, 0, lw8,  0, 1);
        step(z,    0, 0, z,    0, 1);
        // hold beats hazard, hazard re-evaluated after
        step(lw8,  0, 0, z,    0, 1);
        step(addd, 0, 1, lw8,  1, 1);
        step(addd, 0, 0, lw8,  1, 1);
        step(addd, 0, 0, z,    0, 2);
        // hold freezes a live instruction
        step(add1, 0, 1, addd, 1, 2);
        step(add1, 0, 0, addd, 0, 2);
        step(lw8,  0, 0, add1, 0, 2);
        step(addd, 0, 0, lw8,  1, 2);
        // async reset mid-stall clears everything before the next edge
        rst_n = 1'b0;
        step(addd, 0, 0, z,    0, 0);
        rst_n = 1'b1;
        step(addd, 0, 0, z,    0, 0);
        step(z,    0, 0, addd, 0, 0);
        // saturation over 17 load-use pairs
        for (int i = 0; i < 17; i++) begin
            step(lw8,  0, 0, (i == 0) ? z : addd, 0, sat(i));
            step(addd, 0, 0, lw8, 1, sat(i));
            step(addd, 0, 0, z,   0, sat(i + 1));
        end
        step(z, 0, 0, addd, 0, 4'hF);
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline boundary for the five-stage MIPS core. It latches decoded operands, register specifiers and main-control signals from ID, and presents them to EX, where `ex_alu_op` and `ex_funct` drive the ALU control decoder. It also performs load-use hazard detection, inserting bubbles and stalling upstream stages. Branch flushes and downstream holds are applied here.

## Interface
Parameters:
- `DW`, 32: datapath width (PC, operands, immediate).
- `PCW`, 16: width of the bubble performance counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_pc_plus4`, `id_rs_data`, `id_rt_data`, `id_imm`  in  DW each  PC+4, register-file reads, sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd`  in  5 each  register specifiers.
- `id_funct`  in  6  instruction bits [5:0].
- `id_alu_op`  in  2  main-control ALUOp (00 mem, 01 beq, 10 R-type).
- `id_reg_write`, `id_mem_to_reg`, `id_mem_read`, `id_mem_write`, `id_branch`, `id_alu_src`, `id_reg_dst`  in  1 each  main-control signals.
- `flush_i`  in  1  branch taken in EX/MEM; kill the ID instruction.
- `hold_i`  in  1  downstream busy; freeze this register.
- `ex_valid`  out  1  EX holds a real instruction.
- `ex_pc_plus4`, `ex_rs_data`, `ex_rt_data`, `ex_imm`  out  DW each  registered copies.
- `ex_rs`, `ex_rt`, `ex_rd`, `ex_funct`, `ex_alu_op`  out  5/5/5/6/2  registered copies.
- `ex_reg_write`, `ex_mem_to_reg`, `ex_mem_read`, `ex_mem_write`, `ex_branch`, `ex_alu_src`, `ex_reg_dst`  out  1 each  registered controls.
- `stall_o`  out  1  combinational; hold PC and IF/ID this cycle.
- `perf_bubbles`  out  PCW  saturating count of load-use bubbles.

## Operation
- Hazard, combinational: `haz = ex_valid & ex_mem_read & id_valid & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt))`.
  - `id_rt` is compared for every opcode (conservative).
  - Register 0 never creates a hazard.
- `stall_o = (haz | hold_i) & ~flush_i`.
- Update priority at each rising edge, highest first:
  1. `flush_i`: load a bubble.
  2. `hold_i`: all outputs keep their values.
  3. `haz`: load a bubble; `perf_bubbles` increments.
  4. Otherwise: load all `id_*` fields; `ex_valid <= id_valid`.
- Bubble: `ex_valid` = 0, all seven control outputs = 0, `ex_alu_op` = 00, and every data, specifier and `ex_funct` field = 0.
- When `id_valid` = 0 and no higher-priority condition applies, the fields load as-is. Downstream qualifies everything with `ex_valid`.
- `perf_bubbles` counts only hazard bubbles, not flushes. It saturates at all-ones; it does not wrap.
- No internal FSM beyond the register. The EX-stage state is either VALID or BUBBLE, reflected by `ex_valid`.

## Timing
- Reset (async assert, sync release at the clock): every output register = 0, including `ex_valid` and `perf_bubbles`. `stall_o` is then 0 because `ex_valid` = 0.
- Latency: ID inputs appear on `ex_*` one cycle after the edge that samples them.
- A load-use pair costs exactly one bubble:
  - Cycle N: `stall_o` = 1 and `perf_bubbles` increments at the edge.
  - Cycle N+1: EX holds the bubble; the dependent instruction is still in ID. `haz` = 0 because `ex_mem_read` = 0. It loads at the next edge.
- `flush_i` together with `haz`: the flush wins, `stall_o` = 0, and the counter does not increment.
- `hold_i` together with `haz`: the register holds, the counter does not increment, and `stall_o` = 1. The hazard is re-evaluated next cycle.
- `rst_n` asserted mid-stall: outputs clear immediately; no bubble or count is retained.

## Test plan
- Reset: drive `rst_n` = 0 with all inputs = 1s → all `ex_*` = 0, `ex_valid` = 0, `stall_o` = 0, `perf_bubbles` = 0.
- Pass-through: issue `add` (`id_alu_op` = 10, `id_funct` = 0x20, `id_rs` = 9, `id_rt` = 10, `id_rd` = 8, `id_reg_write` = 1) → next cycle `ex_*` match the inputs, `ex_valid` = 1, `stall_o` = 0 throughout.
- Load-use:
  - Setup: `lw` with `ex_rt` = 8 in EX, then `add` with `id_rs` = 8 in ID.
  - Required: `stall_o` = 1 for one cycle.
  - Required: next cycle `ex_valid` = 0, all controls = 0, `perf_bubbles` = 1.
  - Required: the following cycle `ex_rs` = 8, `ex_valid` = 1.
- $0 exclusion: `lw` with `ex_rt` = 0, then `id_rs` = 0 → `stall_o` = 0, no bubble, count unchanged.
- Priority:
  - Hazard plus `flush_i` = 1 → bubble, `stall_o` = 0, count unchanged.
  - Hazard plus `hold_i` = 1 → outputs unchanged, `stall_o` = 1, count unchanged.
- Saturation: with `PCW` = 4, force 17 load-use hazards → `perf_bubbles` = 0xF after the 15th and stays 0xF.
